axi_atomic_arbiter: RTL

//  Shares the single AXI-lite slave port of ram_axi between NUM_CORES RISC-V cores.

---
 rtl/axi_arb_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/axi_atomic_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and response codes for the atomic-aware AXI-lite arbiter.
package axi_arb_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_CHK,
        WR_ADDR,
        WR_WAIT,
        WR_RESP,
        RD_ADDR,
        RD_WAIT,
        RD_RESP
    } state_t;

    // A forwarded SC reports EXOKAY unless the RAM itself flagged an error.
    function automatic logic [1:0] sc_resp(input logic [1:0] ram_resp);
        return (ram_resp == RESP_OKAY) ? RESP_EXOKAY : ram_resp;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection with a rotating priority pointer.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [IW-1:0] ptr_q, ptr_d;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!gnt_any && req[(int'(ptr_q) + i) % N]) begin
                gnt_any                        = 1'b1;
                gnt[(int'(ptr_q) + i) % N]     = 1'b1;
                gnt_idx                        = IW'((int'(ptr_q) + i) % N);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && gnt_any) begin
            ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/axi_atomic_arbiter.sv
// Shares one AXI-lite RAM port between several cores, one transaction at a time,
// resolving LR/SC locally with one word-granular reservation per core.
module axi_atomic_arbiter
    import axi_arb_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 10,
    parameter int NUM_CORES       = 2,
    parameter int MASTER_ID_WIDTH = $clog2(NUM_CORES)
) (
    input  logic                               axi_aclk,
    input  logic                               axi_areset,
    input  logic [NUM_CORES-1:0]               s_awvalid,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0]    s_awaddr,
    input  logic [NUM_CORES-1:0]               s_awlock,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]    s_wdata,
    input  logic [NUM_CORES*DATA_WIDTH/8-1:0]  s_wstrb,
    output logic [NUM_CORES-1:0]               s_awready,
    output logic [NUM_CORES-1:0]               s_bvalid,
    input  logic [NUM_CORES-1:0]               s_bready,
    output logic [1:0]                         s_bresp,
    input  logic [NUM_CORES-1:0]               s_arvalid,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0]    s_araddr,
    input  logic [NUM_CORES-1:0]               s_arlock,
    output logic [NUM_CORES-1:0]               s_arready,
    output logic [NUM_CORES-1:0]               s_rvalid,
    input  logic [NUM_CORES-1:0]               s_rready,
    output logic [DATA_WIDTH-1:0]              s_rdata,
    output logic [1:0]                         s_rresp,
    output logic [ADDR_WIDTH-1:0]              m_awaddr,
    output logic [2:0]                         m_awprot,
    output logic                               m_awvalid,
    output logic [MASTER_ID_WIDTH-1:0]         m_awid,
    output logic                               m_awlock,
    input  logic                               m_awready,
    output logic [DATA_WIDTH-1:0]              m_wdata,
    output logic [DATA_WIDTH/8-1:0]            m_wstrb,
    output logic                               m_wvalid,
    input  logic                               m_wready,
    input  logic [1:0]                         m_bresp,
    input  logic                               m_bvalid,
    input  logic [MASTER_ID_WIDTH-1:0]         m_bid,
    output logic                               m_bready,
    output logic [ADDR_WIDTH-1:0]              m_araddr,
    output logic [2:0]                         m_arprot,
    output logic                               m_arvalid,
    output logic [MASTER_ID_WIDTH-1:0]         m_arid,
    output logic                               m_arlock,
    input  logic                               m_arready,
    input  logic [DATA_WIDTH-1:0]              m_rdata,
    input  logic [1:0]                         m_rresp,
    input  logic                               m_rvalid,
    input  logic [MASTER_ID_WIDTH-1:0]         m_rid,
    output logic                               m_rready,
    output logic [NUM_CORES-1:0]               core_block,
    output state_t                             dbg_state
);

    localparam int IW = MASTER_ID_WIDTH;
    localparam int WA = ADDR_WIDTH - 2;
    localparam int SW = DATA_WIDTH / 8;

    // Handshakes: a transfer happens on the rising edge where valid and ready are
    // both high; valid and its payload stay stable until then. s_awready/s_arready
    // are single-cycle accept pulses, so a core drops its valid after seeing one.

    state_t                         state_q, state_d;
    logic [IW-1:0]                  gnt_q, gnt_d;
    logic [ADDR_WIDTH-1:0]          aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
    logic [DATA_WIDTH-1:0]          w_data_q, w_data_d, rdata_q, rdata_d;
    logic [SW-1:0]                  w_strb_q, w_strb_d;
    logic                           aw_lock_q, aw_lock_d, ar_lock_q, ar_lock_d;
    logic                           aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [1:0]                     resp_q, resp_d;
    logic [NUM_CORES-1:0]           resv_vld_q, resv_vld_d;
    logic [NUM_CORES-1:0][WA-1:0]   resv_addr_q, resv_addr_d;

    logic [NUM_CORES-1:0]           req, arb_gnt, cur_gnt;
    logic [IW-1:0]                  arb_idx;
    logic                           arb_any;

    assign req = s_awvalid | s_arvalid;

    rr_arbiter #(.N(NUM_CORES), .IW(IW)) u_rr (
        .clk     (axi_aclk),
        .rst     (axi_areset),
        .req     (req),
        .advance (state_q == IDLE),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    assign m_awaddr  = aw_addr_q;
    assign m_awprot  = 3'b000;
    assign m_awid    = gnt_q;
    assign m_awlock  = 1'b0;
    assign m_wdata   = w_data_q;
    assign m_wstrb   = w_strb_q;
    assign m_araddr  = ar_addr_q;
    assign m_arprot  = 3'b000;
    assign m_arid    = gnt_q;
    assign m_arlock  = 1'b0;
    assign dbg_state = state_q;

    always_comb begin
        cur_gnt = '0;
        if (state_q == IDLE) begin
            cur_gnt = arb_gnt;
        end else begin
            cur_gnt[gnt_q] = 1'b1;
        end
        core_block = req & ~cur_gnt;
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        aw_addr_d   = aw_addr_q;
        w_data_d    = w_data_q;
        w_strb_d    = w_strb_q;
        aw_lock_d   = aw_lock_q;
        ar_addr_d   = ar_addr_q;
        ar_lock_d   = ar_lock_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        resp_d      = resp_q;
        rdata_d     = rdata_q;
        resv_vld_d  = resv_vld_q;
        resv_addr_d = resv_addr_q;
        s_awready   = '0;
        s_arready   = '0;
        s_bvalid    = '0;
        s_rvalid    = '0;
        s_bresp     = 2'b00;
        s_rresp     = 2'b00;
        s_rdata     = '0;
        m_awvalid   = 1'b0;
        m_wvalid    = 1'b0;
        m_bready    = 1'b0;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    gnt_d = arb_idx;
                    if (s_awvalid[arb_idx]) begin
                        s_awready = arb_gnt;
                        aw_addr_d = s_awaddr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                        w_data_d  = s_wdata[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
                        w_strb_d  = s_wstrb[int'(arb_idx)*SW +: SW];
                        aw_lock_d = s_awlock[arb_idx];
                        state_d   = WR_CHK;
                    end else begin
                        s_arready = arb_gnt;
                        ar_addr_d = s_araddr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                        ar_lock_d = s_arlock[arb_idx];
                        state_d   = RD_ADDR;
                    end
                end
            end
            WR_CHK: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (aw_lock_q && aw_addr_q[1:0] != 2'b00) begin
                    resp_d  = RESP_SLVERR;
                    state_d = WR_RESP;
                end else if (aw_lock_q && (!resv_vld_q[gnt_q] ||
                             resv_addr_q[gnt_q] != aw_addr_q[ADDR_WIDTH-1:2])) begin
                    // Failed SC: dropped, and the requester loses its reservation.
                    resp_d             = RESP_OKAY;
                    resv_vld_d[gnt_q]  = 1'b0;
                    state_d            = WR_RESP;
                end else begin
                    state_d = WR_ADDR;
                end
            end
            WR_ADDR: begin
                m_awvalid = !aw_done_q;
                m_wvalid  = !w_done_q;
                aw_done_d = aw_done_q | m_awready;
                w_done_d  = w_done_q | m_wready;
                if (aw_done_d && w_done_d) begin
                    state_d = WR_WAIT;
                end
            end
            WR_WAIT: begin
                m_bready = 1'b1;
                if (m_bvalid && m_bid == gnt_q) begin
                    resp_d = aw_lock_q ? sc_resp(m_bresp) : m_bresp;
                    // Any reservation on the written word is now stale, the writer's included.
                    for (int i = 0; i < NUM_CORES; i++) begin
                        if (resv_addr_q[i] == aw_addr_q[ADDR_WIDTH-1:2]) begin
                            resv_vld_d[i] = 1'b0;
                        end
                    end
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                s_bvalid[gnt_q] = 1'b1;
                s_bresp         = resp_q;
                if (s_bready[gnt_q]) begin
                    state_d = IDLE;
                end
            end
            RD_ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                m_rready = 1'b1;
                if (m_rvalid && m_rid == gnt_q) begin
                    rdata_d = m_rdata;
                    resp_d  = m_rresp;
                    if (ar_lock_q) begin
                        resv_vld_d[gnt_q]  = 1'b1;
                        resv_addr_d[gnt_q] = ar_addr_q[ADDR_WIDTH-1:2];
                    end
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                s_rvalid[gnt_q] = 1'b1;
                s_rdata         = rdata_q;
                s_rresp         = resp_q;
                if (s_rready[gnt_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            aw_addr_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            aw_lock_q   <= 1'b0;
            ar_addr_q   <= '0;
            ar_lock_q   <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            resp_q      <= 2'b00;
            rdata_q     <= '0;
            resv_vld_q  <= '0;
            resv_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            aw_addr_q   <= aw_addr_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            aw_lock_q   <= aw_lock_d;
            ar_addr_q   <= ar_addr_d;
            ar_lock_q   <= ar_lock_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            resp_q      <= resp_d;
            rdata_q     <= rdata_d;
            resv_vld_q  <= resv_vld_d;
            resv_addr_q <= resv_addr_d;
        end
    end

endmodule
